// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: direct-mapped instruction fetch buffer that refills misses from RAM.
// Sequential next-line prefetch is built only when INST_PREFETCH_EN is defined.
module inst_fetch_ctrl #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter int                IDX_W    = 3,
   parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              work_done,
   input  logic              flush,
   output logic              ram_req,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic              ram_ack,
   input  logic [DATA_W-1:0] ram_data
);
   localparam int N     = 1 << IDX_W;
   localparam int TAG_W = ADDR_W - IDX_W;

`ifdef INST_PREFETCH_EN
   typedef enum logic [1:0] {IDLE, FETCH, PREF} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH} state_t;
`endif

   state_t            state_q, state_d;
   logic [N-1:0]      valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q [N];
   logic [DATA_W-1:0] word_q [N];
   logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
   logic              req_q, req_d;
   logic              stale_q, stale_d;
   logic [IDX_W-1:0]  idx, fidx;
   logic              hit, wr;

   assign idx       = addr[IDX_W-1:0];
   assign fidx      = fill_addr_q[IDX_W-1:0];
   assign hit       = valid_q[idx] && (tag_q[idx] == addr[ADDR_W-1:IDX_W]);
   assign data      = hit ? word_q[idx] : NOP_WORD;
   assign work_done = hit;
   assign ram_req   = req_q;
   assign ram_addr  = fill_addr_q;
   // A flush in the ack cycle or any earlier point of the fill discards the returned word
   assign wr        = (state_q != IDLE) && ram_ack && !stale_q && !flush;

`ifdef INST_PREFETCH_EN
   logic [ADDR_W-1:0] last_q, last_d, pf_addr;
   logic [IDX_W-1:0]  pidx;
   logic              pf_pend_q, pf_pend_d, pf_hit;

   assign pf_addr = last_q + ADDR_W'(1);
   assign pidx    = pf_addr[IDX_W-1:0];
   assign pf_hit  = valid_q[pidx] && (tag_q[pidx] == pf_addr[ADDR_W-1:IDX_W]);
`endif

   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      req_d       = req_q;
      stale_d     = stale_q | (flush && state_q != IDLE);
      valid_d     = flush ? '0 : valid_q;
`ifdef INST_PREFETCH_EN
      pf_pend_d   = pf_pend_q && !flush;
      last_d      = last_q;
`endif
      if (state_q == IDLE) begin
         if (!hit && !flush) begin
            state_d     = FETCH;
            fill_addr_d = addr;
            req_d       = 1'b1;
            stale_d     = 1'b0;
         end
`ifdef INST_PREFETCH_EN
         // One prefetch attempt per demand fill, so a conflicting demand line cannot thrash
         else if (pf_pend_q && !flush) begin
            pf_pend_d = 1'b0;
            if (!pf_hit) begin
               state_d     = PREF;
               fill_addr_d = pf_addr;
               req_d       = 1'b1;
               stale_d     = 1'b0;
            end
         end
`endif
      end else if (ram_ack) begin
         state_d = IDLE;
         req_d   = 1'b0;
         stale_d = 1'b0;
      end
      if (wr) valid_d[fidx] = 1'b1;
`ifdef INST_PREFETCH_EN
      if (wr && state_q == FETCH) begin
         last_d    = fill_addr_q;
         pf_pend_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         fill_addr_q <= '0;
         req_q       <= 1'b0;
         stale_q     <= 1'b0;
`ifdef INST_PREFETCH_EN
         pf_pend_q   <= 1'b0;
         last_q      <= '0;
`endif
         for (int i = 0; i < N; i++) begin
            tag_q[i]  <= '0;
            word_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         fill_addr_q <= fill_addr_d;
         req_q       <= req_d;
         stale_q     <= stale_d;
`ifdef INST_PREFETCH_EN
         pf_pend_q   <= pf_pend_d;
         last_q      <= last_d;
`endif
         if (wr) begin
            tag_q[fidx]  <= fill_addr_q[ADDR_W-1:IDX_W];
            word_q[fidx] <= ram_data;
         end
      end
   end
endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, instruction address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 SHALL have parameter IDX_W, default 3, buffer index width; the buffer holds 2**IDX_W direct-mapped entries, and IDX_W < ADDR_W.
REQ-004 SHALL have parameter NOP_WORD, default 16'h0800, the word returned on a miss.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- addr  in  ADDR_W  PC to fetch.
- data  out  DATA_W  instruction for addr.
- work_done  out  1  data is valid for addr this cycle.
- flush  in  1  invalidate all entries.
- ram_req  out  1  RAM read request.
- ram_addr  out  ADDR_W  RAM read address.
- ram_ack  in  1  one-cycle pulse; ram_data valid.
- ram_data  in  DATA_W  RAM read word.

Function
REQ-006 SHALL form index = addr[IDX_W-1:0] and tag = addr[ADDR_W-1:IDX_W].
REQ-007 Hit SHALL mean valid[index] set and stored tag equal to the addr tag; on a hit, data = stored word and work_done = 1 combinationally, in the same cycle.
REQ-008 On a miss, data SHALL equal NOP_WORD and work_done SHALL be 0.
REQ-009 The FSM SHALL have states IDLE, FETCH and (under the macro only) PREF.
REQ-010 IDLE -> FETCH SHALL occur when the FSM is in IDLE, addr misses and flush = 0; at that edge, fill_addr and ram_addr latch addr and ram_req is registered high (ram_req rises the cycle after the miss is seen).
REQ-011 In FETCH, ram_req and ram_addr SHALL hold stable until ram_ack.
REQ-012 On ram_ack, the entry indexed by fill_addr SHALL be written (tag, word, valid = 1), ram_req SHALL drop at the same edge, and the FSM SHALL return to IDLE. Miss latency with a 1-cycle RAM is therefore 3 cycles to work_done.
REQ-013 A change of addr during FETCH SHALL NOT abort the fill; fill_addr is written on ack and the new addr is evaluated from IDLE afterwards.
REQ-014 flush SHALL clear every valid bit at the next edge. A flush asserted during FETCH or PREF SHALL mark the outstanding fill stale; a stale fill is discarded on ack.
REQ-015 When flush and ram_ack are high in the same cycle, flush SHALL win: no entry is written.
REQ-016 ram_ack outside FETCH/PREF SHALL be ignored.
REQ-017 Address arithmetic SHALL wrap modulo 2**ADDR_W.

Reset
REQ-018 While rst = 0: state = IDLE, all valid bits = 0, ram_req = 0, ram_addr = 0, stale = 0, data = NOP_WORD, work_done = 0.
REQ-019 A reset asserted mid-fetch SHALL abandon the fetch; a ram_ack arriving after release while in IDLE is ignored.

Configuration
REQ-020 The macro INST_PREFETCH_EN SHALL enable sequential prefetch. When defined: in IDLE with no demand miss, if the last demand fill address plus 1 misses the buffer, the block issues a PREF request for that address (same handshake and write rules as FETCH). A demand miss arriving during PREF waits for PREF to complete and is then served from IDLE. When not defined: no PREF state and only demand fetches are made.

Verification
REQ-021 Reset, then addr = 0x0010, RAM ack 1 cycle after req with 0x1234 -> ram_req high at cycle 1 with ram_addr = 0x0010; work_done = 1 and data = 0x1234 at cycle 3; data = 0x0800 before that.
REQ-022 Fill 0x0010, then addr = 0x0018 (same index, other tag), then back to 0x0010 -> each access misses and refetches; ram_addr is 0x0018, then 0x0010.
REQ-023 Fill 0x0020, then pulse flush, then addr = 0x0020 -> work_done = 0 the cycle after flush and a new ram_req is issued for 0x0020.
REQ-024 During FETCH of 0x0030, assert flush in the same cycle as ram_ack -> no entry is written; a re-request of 0x0030 follows.
REQ-025 With INST_PREFETCH_EN, fill 0xFFFF -> a PREF request for 0x0000 follows (wrap), and addr = 0x0000 then hits with zero extra fetch; without the macro, ram_req stays low after the fill.
